// File: rtl/gamepad_responder.sv
// rtl/gamepad_responder.sv - controller end of the (S)NES serial pad link
module gamepad_responder #(
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit FILL_LEVEL  = 1'b0,
  parameter int TIMEOUT     = 4800,
  parameter int LOG_TIMEOUT = $clog2(TIMEOUT)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pad_latch,
  input  logic        pad_clk,
  output logic        pad_data,
  input  logic [15:0] buttons,
  input  logic        buttons_we,
  output logic        busy,
  output logic [4:0]  bit_cnt,
  output logic        frame_done,
  output logic        timeout,
  output logic        extra_clk
);

  typedef enum logic [1:0] {S_IDLE, S_LATCHED, S_SHIFTING, S_DONE} state_t;

  state_t                 state, state_n;
  logic [15:0]            hold;
  logic [15:0]            sh, sh_n;
  logic [4:0]             cnt_n;
  logic [LOG_TIMEOUT-1:0] to_cnt, to_n;
  logic                   fd_n, tmo_n, xc_n;
  logic [15:0]            load_val;

  logic latch_s1, latch_s2, latch_s3;
  logic clk_s1, clk_s2, clk_s3;
  logic latch_rise, latch_fall, clk_ok;

  assign latch_rise = latch_s2 & ~latch_s3;
  assign latch_fall = ~latch_s2 & latch_s3;
  // Console clock edges only count while the latch is low.
  assign clk_ok     = clk_s2 & ~clk_s3 & ~latch_s2;
  assign load_val   = ACTIVE_LOW ? ~hold : hold;

  // Two-flop synchronisers plus a previous-value stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      {latch_s1, latch_s2, latch_s3} <= 3'b000;
      {clk_s1, clk_s2, clk_s3}       <= 3'b000;
    end else begin
      {latch_s1, latch_s2, latch_s3} <= {pad_latch, latch_s1, latch_s2};
      {clk_s1, clk_s2, clk_s3}       <= {pad_clk, clk_s1, clk_s2};
    end
  end

  // Button hold register; written at any time, only copied into sh while latched.
  always_ff @(posedge clk) begin
    if (rst) hold <= 16'h0000;
    else if (buttons_we) hold <= buttons;
  end

  // Frame state, shift register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sh         <= 16'h0000;
      bit_cnt    <= 5'd0;
      to_cnt     <= '0;
      pad_data   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      extra_clk  <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      bit_cnt    <= cnt_n;
      to_cnt     <= to_n;
      pad_data   <= (state_n == S_IDLE) ? 1'b1 : sh_n[0];
      busy       <= (state_n == S_LATCHED) || (state_n == S_SHIFTING);
      frame_done <= fd_n;
      timeout    <= tmo_n;
      extra_clk  <= xc_n;
    end
  end

  // Next-state logic; a latch rise overrides everything, including a clock edge.
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = bit_cnt;
    to_n    = to_cnt;
    fd_n    = 1'b0;
    tmo_n   = 1'b0;
    xc_n    = 1'b0;
    if (latch_rise) begin
      state_n = S_LATCHED;
      sh_n    = load_val;
      cnt_n   = 5'd0;
      to_n    = '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_n = 5'd0;
          to_n  = '0;
        end
        S_LATCHED: begin
          sh_n  = load_val;
          cnt_n = 5'd0;
          to_n  = '0;
          if (latch_fall) state_n = S_SHIFTING;
        end
        S_SHIFTING: begin
          if (clk_ok) begin
            sh_n  = {FILL_LEVEL, sh[15:1]};
            cnt_n = bit_cnt + 5'd1;
            to_n  = '0;
            if (bit_cnt == 5'd15) begin
              fd_n    = 1'b1;
              state_n = S_DONE;
            end
          end else if (to_cnt == LOG_TIMEOUT'(TIMEOUT - 1)) begin
            tmo_n   = 1'b1;
            state_n = S_IDLE;
            cnt_n   = 5'd0;
            to_n    = '0;
          end else begin
            to_n = to_cnt + LOG_TIMEOUT'(1);
          end
        end
        S_DONE: begin
          if (clk_ok) xc_n = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_responder.sv
// tb/tb_gamepad_responder.sv - randomized self-checking bench for gamepad_responder
module tb_gamepad_responder;

  localparam bit AL   = 1'b1;
  localparam bit FILL = 1'b0;
  localparam int TO   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pad_latch = 1'b0;
  logic        pad_clk = 1'b0;
  logic        pad_data;
  logic [15:0] buttons = 16'h0000;
  logic        buttons_we = 1'b0;
  logic        busy;
  logic [4:0]  bit_cnt;
  logic        frame_done, timeout, extra_clk;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0, to_cnt = 0, xc_cnt = 0;
  logic [15:0] hold_model = 16'h0000;
  logic [15:0] frame_word;

  gamepad_responder #(.ACTIVE_LOW(AL), .FILL_LEVEL(FILL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .pad_data(pad_data), .buttons(buttons), .buttons_we(buttons_we),
    .busy(busy), .bit_cnt(bit_cnt), .frame_done(frame_done),
    .timeout(timeout), .extra_clk(extra_clk)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (timeout)    to_cnt++;
    if (extra_clk)  xc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line level the console should see before rise k when the frame snapshot is w.
  function automatic logic [31:0] exp_line(input logic [15:0] w, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++)
      r[k] = (k < 16) ? (AL ? ~w[k] : w[k]) : FILL;
    return r;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_buttons(input logic [15:0] v);
    @(negedge clk);
    buttons = v;
    buttons_we = 1'b1;
    @(negedge clk);
    buttons_we = 1'b0;
    hold_model = v;
  endtask

  task automatic latch_pulse();
    @(negedge clk);
    pad_latch = 1'b1;
    wait_cycles($urandom_range(3, 6));
    pad_latch = 1'b0;
    frame_word = hold_model;
    wait_cycles($urandom_range(3, 6));
  endtask

  task automatic clocks(input int n, output logic [31:0] line);
    line = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      line[k] = pad_data;
      pad_clk = 1'b1;
      wait_cycles($urandom_range(3, 5));
      pad_clk = 1'b0;
      wait_cycles($urandom_range(3, 5));
    end
  endtask

  initial begin
    logic [31:0] line;
    int fd0, to0, xc0, n;

    wait_cycles(3);
    check("reset_pad_data", pad_data, 1);
    check("reset_busy", busy, 0);
    check("reset_bit_cnt", bit_cnt, 0);
    check("reset_pulses", {frame_done, timeout, extra_clk}, 0);
    rst = 1'b0;
    wait_cycles(2);

    // Basic frame with 16'h8001.
    write_buttons(16'h8001);
    fd0 = fd_cnt;
    latch_pulse();
    check("latched_busy", busy, 1);
    clocks(16, line);
    check("frame_8001_line", line, exp_line(16'h8001, 16));
    check("frame_8001_done", fd_cnt - fd0, 1);
    check("frame_8001_cnt", bit_cnt, 16);
    check("done_busy", busy, 0);

    // Extra clocks after the frame.
    xc0 = xc_cnt;
    clocks(2, line);
    check("extra_line", line, {30'd0, FILL, FILL});
    check("extra_pulses", xc_cnt - xc0, 2);
    check("extra_cnt", bit_cnt, 16);

    // Restart mid-frame.
    fd0 = fd_cnt;
    latch_pulse();
    clocks(5, line);
    check("restart_partial_cnt", bit_cnt, 5);
    write_buttons(16'h00FF);
    latch_pulse();
    check("restart_cnt_cleared", bit_cnt, 0);
    clocks(16, line);
    check("restart_line", line, exp_line(16'h00FF, 16));
    check("restart_done_once", fd_cnt - fd0, 1);

    // Timeout.
    to0 = to_cnt;
    latch_pulse();
    clocks(3, line);
    wait_cycles(TO + 5);
    check("timeout_pulse", to_cnt - to0, 1);
    check("timeout_pad_data", pad_data, 1);
    check("timeout_cnt", bit_cnt, 0);
    check("timeout_busy", busy, 0);

    // Snapshot: a write during SHIFTING does not disturb the frame in flight.
    latch_pulse();
    write_buttons(16'hFFFF);
    clocks(16, line);
    check("snapshot_old", line, exp_line(frame_word, 16));
    check("snapshot_old_is_00ff", frame_word, 16'h00FF);
    latch_pulse();
    clocks(16, line);
    check("snapshot_new", line, exp_line(16'hFFFF, 16));

    // Reset after bit 7.
    latch_pulse();
    clocks(8, line);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_pad_data", pad_data, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt", bit_cnt, 0);
    rst = 1'b0;
    hold_model = 16'h0000;
    wait_cycles(2);
    latch_pulse();
    clocks(17, line);
    check("post_rst_line", line, exp_line(16'h0000, 17));

    // Randomized frames of random length.
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 1)) write_buttons(16'($urandom));
      n = $urandom_range(1, 20);
      fd0 = fd_cnt; xc0 = xc_cnt; to0 = to_cnt;
      latch_pulse();
      clocks(n, line);
      check("rand_line", line, exp_line(frame_word, n));
      check("rand_cnt", bit_cnt, (n < 16) ? n : 16);
      check("rand_done", fd_cnt - fd0, (n >= 16) ? 1 : 0);
      check("rand_extra", xc_cnt - xc0, (n > 16) ? n - 16 : 0);
      if (n < 16) begin
        wait_cycles(TO + 5);
        check("rand_timeout", to_cnt - to0, 1);
        check("rand_timeout_data", pad_data, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gamepad_responder.md
# gamepad_responder

Emulates the controller end of the (S)NES serial gamepad link so the FPGA can act as a virtual pad for a console or for our own gamepad reader. Takes a 16-bit button word from user logic, snapshots it on the console's latch pulse and shifts it out one bit per rising edge of the console's clock. Link inputs are asynchronous and are synchronised internally. Status pulses report completed frames, aborted frames and protocol overruns.

## Interface

- ACTIVE_LOW, 1: 1 = line driven low for a pressed button (genuine pad behaviour); 0 = line high for pressed.
- FILL_LEVEL, 0: line level shifted in behind the 16 data bits; it is driven after the 16th clock.
- TIMEOUT, 4800: clk cycles without a pad_clk rising edge in SHIFTING before the frame is abandoned (400 µs at 12 MHz).
- LOG_TIMEOUT, $clog2(TIMEOUT): counter width.

- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- pad_latch  in  1  console latch, asynchronous.
- pad_clk  in  1  console clock, asynchronous, idle low.
- pad_data  out  1  serial data line to console (registered).
- buttons  in  16  button state, 1 = pressed; bit 0 is sent first.
- buttons_we  in  1  one-cycle write strobe; captures buttons into hold register.
- busy  out  1  high in LATCHED or SHIFTING.
- bit_cnt  out  5  pad_clk rising edges counted in the current frame, 0..16.
- frame_done  out  1  one-cycle pulse on the 16th pad_clk rise.
- timeout  out  1  one-cycle pulse when a frame is abandoned.
- extra_clk  out  1  one-cycle pulse per pad_clk rise seen in DONE.

## Operation

- Synchroniser: 2-FF chains on pad_latch and pad_clk, plus a third "previous" register each. The rise/fall strobes come from stage 2 vs stage 3.
- Hold register hold[15:0]: reset 0. It loads buttons on buttons_we in any state. It never disturbs an in-flight shift.
- Shift register sh[15:0] holds line levels. A load writes (ACTIVE_LOW ? ~hold : hold). A shift writes {FILL_LEVEL, sh[15:1]}.
- pad_data = 1 in IDLE, otherwise sh[0].
- States:
  - IDLE: latch rise -> LATCHED. pad_clk edges are ignored.
  - LATCHED: sh is reloaded every cycle, so a buttons_we while latch is high is reflected. bit_cnt=0. Latch fall -> SHIFTING with sh frozen. pad_clk rises are ignored.
  - SHIFTING: each pad_clk rise shifts sh and increments bit_cnt. The rise that makes bit_cnt=16 pulses frame_done and moves to DONE. A rise resets the timeout counter. If the counter reaches TIMEOUT-1 with no rise: pulse timeout, go to IDLE, bit_cnt=0.
  - DONE: pad_data holds FILL_LEVEL. Each pad_clk rise pulses extra_clk; sh and bit_cnt are unchanged (saturated at 16).
- A latch rise in any state goes to LATCHED, reloads sh and clears bit_cnt and the timeout counter. This restarts a frame mid-shift.
- A latch rise and a pad_clk rise in the same cycle: the latch wins and the clock edge is dropped.
- A pad_clk rise while the synchronised latch is high is ignored.
- Reset, including mid-frame:
  - state=IDLE; hold, sh, bit_cnt and the timeout counter = 0.
  - pad_data=1; busy, frame_done, timeout and extra_clk = 0.
  - All synchroniser stages = 0.

## Timing

- A pin transition first sampled at edge n appears in stage 2 at n+1. The resulting state, sh and pad_data update is registered at edge n+2.
- Pin-to-pad_data latency is therefore 2–3 clk cycles. A console must not sample pad_data sooner than 3 clk periods after its own pad_clk rise or latch edge.
- Minimum pad_latch/pad_clk high or low width: 3 clk cycles. Shorter pulses may be lost; this is not an error.
- frame_done, timeout and extra_clk rise in the same cycle as the corresponding state/bit_cnt update and last exactly one cycle.
- busy and bit_cnt are registered and update in the same edge as the state.
- buttons_we takes effect on hold at the next edge. In LATCHED it reaches sh one edge later.

## Test plan

- Load buttons=16'h8001 (ACTIVE_LOW=1), then latch pulse and 16 pad_clk pulses. Sampled line before each rise = 0,1,1,…,1,0. frame_done pulses once, and bit_cnt ends at 16.
- After that frame, send 2 further pad_clk pulses. pad_data=FILL_LEVEL=0 both times, extra_clk pulses twice, and bit_cnt stays 16.
- Restart: latch, send 5 clocks, then latch again and 16 clocks with buttons=16'h00FF. The second frame reads the full 16'h00FF pattern, and only one frame_done is seen.
- Timeout: latch, 3 clocks, then hold pad_clk low for TIMEOUT+5 cycles. timeout pulses once, state returns to IDLE, pad_data=1, bit_cnt=0, and busy=0.
- Snapshot: latch, then write buttons=16'hFFFF with buttons_we during SHIFTING. The current frame still sends the old hold value, and the next frame sends all-pressed (all 0 on the line).
- Reset asserted after bit 7: next edge gives pad_data=1, busy=0, and hold=0. The following frame sends 16'h0000 (line all 1 for 16 bits, then 0).
